count_ms: RTL and testbench

Minutes/seconds timekeeping stage of the lab digital clock, directly upstream of the hours counter. It counts seconds 00–59 and minutes 00–59 on a one-cycle `enb` tick and accepts a manual minute-advance input. It produces `hr_tick`, which drives the hours counter's `enb` input. It also produces four seven-segment digit patterns for the display multiplexer.

---
 rtl/clock_pkg.sv | 22 ++
 rtl/dec_7seg.sv | 26 ++
 rtl/count_ms.sv | 79 +++++++
 tb/tb_count_ms.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared digital-clock definitions: segment type, digit patterns, default moduli.
// Segment bit order is {g,f,e,d,c,b,a}, active-low.
package clock_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'b1111111;
  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0010000;

  localparam int unsigned SEC_MOD_DEF = 60;
  localparam int unsigned MIN_MOD_DEF = 60;

endpackage

// File: rtl/dec_7seg.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes blank the digit.
module dec_7seg
  import clock_pkg::*;
(
  input  logic [3:0] bcd,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_ms.sv
// Minutes/seconds counter with manual minute advance and hour carry output.
// COUNT_MS_ADV_EDGE_EN: advance once per adv_min rising edge; otherwise level mode gated by enb.
module count_ms
  import clock_pkg::*;
#(
  parameter int unsigned SEC_MOD = SEC_MOD_DEF,
  parameter int unsigned MIN_MOD = MIN_MOD_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  enb,
  input  logic  adv_min,
  output logic  hr_tick,
  output seg7_t m1,
  output seg7_t m0,
  output seg7_t s1,
  output seg7_t s0
);

  localparam int unsigned SW = $clog2(SEC_MOD);
  localparam int unsigned MW = $clog2(MIN_MOD);

  logic [SW-1:0] sec;
  logic [MW-1:0] min;
  logic          sec_last;
  logic          min_last;
  logic          carry;
  logic          adv_step;
  logic          min_inc;
  logic [3:0]    s_tens, s_ones, m_tens, m_ones;

  assign sec_last = (sec == SW'(SEC_MOD - 1));
  assign min_last = (min == MW'(MIN_MOD - 1));
  assign carry    = enb & sec_last;

`ifdef COUNT_MS_ADV_EDGE_EN
  logic adv_q;

  // Reset value 0 makes a button held through reset release count as one edge.
  always_ff @(posedge clk) begin
    if (rst) adv_q <= 1'b0;
    else     adv_q <= adv_min;
  end

  assign adv_step = adv_min & ~adv_q;
`else
  assign adv_step = adv_min & enb;
`endif

  // Carry and manual advance coinciding still move the minute by one.
  assign min_inc = carry | adv_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      sec <= '0;
      min <= '0;
    end else begin
      if (enb)
        sec <= sec_last ? '0 : sec + SW'(1);
      if (min_inc)
        min <= min_last ? '0 : min + MW'(1);
    end
  end

  assign hr_tick = carry & min_last & ~rst;

  always_comb begin
    s_tens = 4'(32'(sec) / 32'd10);
    s_ones = 4'(32'(sec) % 32'd10);
    m_tens = 4'(32'(min) / 32'd10);
    m_ones = 4'(32'(min) % 32'd10);
  end

  dec_7seg u_dec_m1 (.bcd(m_tens), .seg(m1));
  dec_7seg u_dec_m0 (.bcd(m_ones), .seg(m0));
  dec_7seg u_dec_s1 (.bcd(s_tens), .seg(s1));
  dec_7seg u_dec_s0 (.bcd(s_ones), .seg(s0));

endmodule

// File: tb/tb_count_ms.sv
// Directed self-checking bench for count_ms; follows COUNT_MS_ADV_EDGE_EN if defined.
module tb_count_ms;

  logic       clk = 1'b0;
  logic       rst, enb, adv_min;
  logic       hr_tick;
  logic [6:0] m1, m0, s1, s0;

  logic       rst4, enb4, adv4;
  logic       hr_tick4;
  logic [6:0] m1_4, m0_4, s1_4, s0_4;

  int checks = 0;
  int errors = 0;
  logic hr_last;

  count_ms dut (
    .clk(clk), .rst(rst), .enb(enb), .adv_min(adv_min), .hr_tick(hr_tick),
    .m1(m1), .m0(m0), .s1(s1), .s0(s0)
  );

  count_ms #(.SEC_MOD(4), .MIN_MOD(4)) dut4 (
    .clk(clk), .rst(rst4), .enb(enb4), .adv_min(adv4), .hr_tick(hr_tick4),
    .m1(m1_4), .m0(m0_4), .s1(s1_4), .s0(s0_4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic int dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      default:    return 99;
    endcase
  endfunction

  function automatic int secv();
    return dig(s1) * 10 + dig(s0);
  endfunction

  function automatic int minv();
    return dig(m1) * 10 + dig(m0);
  endfunction

  // One clock cycle with the given inputs; hr_tick sampled mid-cycle.
  task automatic cyc(input logic e, input logic a);
    enb = e;
    adv_min = a;
    #2 hr_last = hr_tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int mm, input int ss);
    int base;
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0;
`ifdef COUNT_MS_ADV_EDGE_EN
    repeat (mm) begin
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
    end
    repeat (ss) cyc(1'b1, 1'b0);
`else
    base = 0;
    if (ss < mm) begin
      repeat (60) cyc(1'b1, 1'b0);
      base = 1;
    end
    repeat (mm - base) cyc(1'b1, 1'b1);
    repeat (ss - (mm - base)) cyc(1'b1, 1'b0);
`endif
    enb = 1'b0;
    adv_min = 1'b0;
    if (minv() !== mm || secv() !== ss) begin
      errors++;
      $display("FAIL preload: got %0d:%0d expected %0d:%0d", minv(), secv(), mm, ss);
    end
    checks++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst4 = 1'b1;
    enb4 = 1'b0;
    adv4 = 1'b0;
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    if (hr_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_hr: got %b expected 0", hr_last);
    end
    checks++;
    if ({m1, m0, s1, s0} !== {4{7'b1000000}}) begin
      errors++;
      $display("FAIL reset_digits: got %h expected %h", {m1, m0, s1, s0}, {4{7'b1000000}});
    end
    checks++;
    if ({m1_4, m0_4, s1_4, s0_4} !== {4{7'b1000000}}) begin
      errors++;
      $display("FAIL reset_digits4: got %h expected %h", {m1_4, m0_4, s1_4, s0_4}, {4{7'b1000000}});
    end
    checks++;
    rst = 1'b0;
    rst4 = 1'b0;
    repeat (10) cyc(1'b0, 1'b0);
    if (minv() !== 0 || secv() !== 0 || hr_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: got %0d:%0d hr=%b expected 0:0 hr=0", minv(), secv(), hr_last);
    end
    checks++;
  endtask

  task automatic test_seconds();
    logic hr_any;
    hr_any = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (secv() !== i || minv() !== 0) begin
        errors++;
        $display("FAIL sec_step: got %0d:%0d expected 0:%0d", minv(), secv(), i);
      end
      checks++;
      if (i == 59) begin
        if (s1 !== 7'b0010010 || s0 !== 7'b0010000) begin
          errors++;
          $display("FAIL seg_59: got %b %b expected 0010010 0010000", s1, s0);
        end
        checks++;
      end
      cyc(1'b1, 1'b0);
      hr_any = hr_any | hr_last;
      cyc(1'b0, 1'b0);
      hr_any = hr_any | hr_last;
    end
    if (secv() !== 0 || minv() !== 1 || m0 !== 7'b1111001) begin
      errors++;
      $display("FAIL sec_carry: got %0d:%0d m0=%b expected 1:0 m0=1111001", minv(), secv(), m0);
    end
    checks++;
    if (hr_any !== 1'b0) begin
      errors++;
      $display("FAIL sec_no_hr: got %b expected 0", hr_any);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    preload(0, 0);
    repeat (5) cyc(1'b1, 1'b0);
    enb = 1'b0;
    if (secv() !== 5 || minv() !== 0) begin
      errors++;
      $display("FAIL back_to_back: got %0d:%0d expected 0:5", minv(), secv());
    end
    checks++;
  endtask

  task automatic test_hour_carry();
    preload(59, 58);
    cyc(1'b1, 1'b0);
    if (hr_last !== 1'b0) begin
      errors++;
      $display("FAIL hr_early: got %b expected 0", hr_last);
    end
    checks++;
    cyc(1'b1, 1'b0);
    if (hr_last !== 1'b1) begin
      errors++;
      $display("FAIL hr_pulse: got %b expected 1", hr_last);
    end
    checks++;
    cyc(1'b0, 1'b0);
    if (hr_last !== 1'b0 || minv() !== 0 || secv() !== 0) begin
      errors++;
      $display("FAIL hr_after: got %0d:%0d hr=%b expected 0:0 hr=0", minv(), secv(), hr_last);
    end
    checks++;
  endtask

  task automatic test_manual_wrap();
    logic hr_any;
    preload(59, 58);
`ifdef COUNT_MS_ADV_EDGE_EN
    cyc(1'b0, 1'b1);
    hr_any = hr_last;
    cyc(1'b0, 1'b0);
    hr_any = hr_any | hr_last;
    if (minv() !== 0 || secv() !== 58 || hr_any !== 1'b0) begin
      errors++;
      $display("FAIL manual_wrap: got %0d:%0d hr=%b expected 0:58 hr=0", minv(), secv(), hr_any);
    end
    checks++;
    repeat (20) cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    if (minv() !== 1 || secv() !== 58) begin
      errors++;
      $display("FAIL edge_hold: got %0d:%0d expected 1:58", minv(), secv());
    end
    checks++;
`else
    cyc(1'b1, 1'b1);
    hr_any = hr_last;
    cyc(1'b0, 1'b0);
    hr_any = hr_any | hr_last;
    if (minv() !== 0 || secv() !== 59 || hr_any !== 1'b0) begin
      errors++;
      $display("FAIL manual_wrap: got %0d:%0d hr=%b expected 0:59 hr=0", minv(), secv(), hr_any);
    end
    checks++;
    repeat (3) cyc(1'b0, 1'b1);
    adv_min = 1'b0;
    if (minv() !== 0 || secv() !== 59) begin
      errors++;
      $display("FAIL level_needs_enb: got %0d:%0d expected 0:59", minv(), secv());
    end
    checks++;
`endif
  endtask

  task automatic test_simultaneous();
    preload(10, 59);
    cyc(1'b1, 1'b1);
    if (hr_last !== 1'b0) begin
      errors++;
      $display("FAIL simul_hr: got %b expected 0", hr_last);
    end
    checks++;
    cyc(1'b0, 1'b0);
    if (minv() !== 11 || secv() !== 0) begin
      errors++;
      $display("FAIL simul: got %0d:%0d expected 11:0", minv(), secv());
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    preload(37, 42);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    enb = 1'b0;
    adv_min = 1'b0;
    if (minv() !== 0 || secv() !== 0 || hr_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got %0d:%0d hr=%b expected 0:0 hr=0", minv(), secv(), hr_last);
    end
    checks++;
    preload(59, 59);
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    if (hr_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_hr_mask: got %b expected 0", hr_last);
    end
    checks++;
    cyc(1'b0, 1'b0);
    if (minv() !== 0 || secv() !== 0) begin
      errors++;
      $display("FAIL reset_5959: got %0d:%0d expected 0:0", minv(), secv());
    end
    checks++;
  endtask

  task automatic test_mod4();
    int hr_count;
    hr_count = 0;
    rst4 = 1'b1;
    @(posedge clk);
    #1 rst4 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      enb4 = 1'b1;
      #2 if (hr_tick4 === 1'b1) hr_count++;
      @(posedge clk);
      #1;
      if (i == 4) begin
        if (dig(m0_4) !== 1 || dig(s0_4) !== 1) begin
          errors++;
          $display("FAIL mod4_mid: got %0d:%0d expected 1:1", dig(m0_4), dig(s0_4));
        end
        checks++;
      end
    end
    enb4 = 1'b0;
    if (hr_count !== 1) begin
      errors++;
      $display("FAIL mod4_hr_count: got %0d expected 1", hr_count);
    end
    checks++;
    if (dig(m0_4) !== 0 || dig(s0_4) !== 0) begin
      errors++;
      $display("FAIL mod4_wrap: got %0d:%0d expected 0:0", dig(m0_4), dig(s0_4));
    end
    checks++;
  endtask

  initial begin
    rst = 1'b1;
    enb = 1'b0;
    adv_min = 1'b0;
    rst4 = 1'b1;
    enb4 = 1'b0;
    adv4 = 1'b0;
    hr_last = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_seconds();
    test_back_to_back();
    test_hour_carry();
    test_manual_wrap();
    test_simultaneous();
    test_reset_mid();
    test_mod4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
